// File: rtl/ucsie_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ucsie_pkg
// Brief    : Shared types and constants for the UCIe TX arbitration slice.
// Revision : 1.0
// ============================================================================
package ucsie_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int UCSIE_HDR_W    = 4;
    localparam int UCSIE_CREDIT_W = 8;

endpackage
`default_nettype wire

// File: rtl/ucsie_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ucsie_rr_arbiter
// Brief    : Rotating-priority one-hot pick; search starts at ptr and wraps.
// Revision : 1.0
// ============================================================================
module ucsie_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = PW'((int'(ptr) + i) % N);
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ucsie_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : ucsie_tx_arb
// Brief    : Packet-atomic, credit-gated round-robin scheduler onto the PHY TX.
//            Define UCSIE_TX_ARB_PRIO_EN to give requester 0 strict priority.
// Revision : 1.0
// ============================================================================
module ucsie_tx_arb
    import ucsie_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 256,
    parameter int CREDIT_W   = UCSIE_CREDIT_W,
    parameter int MAX_CREDIT = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           link_ready,
    input  logic [NUM_REQ*DATA_W-1:0]      req_data,
    input  logic [NUM_REQ*UCSIE_HDR_W-1:0] req_header,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_sop,
    input  logic [NUM_REQ-1:0]             req_eop,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_W-1:0]              tx_data,
    output logic [UCSIE_HDR_W-1:0]         tx_header,
    output logic                           tx_valid,
    output logic                           tx_sop,
    output logic                           tx_eop,
    input  logic                           tx_ready,
    input  logic                           crd_ret_vld,
    input  logic [CREDIT_W-1:0]            crd_ret_cnt,
    output logic [CREDIT_W-1:0]            crd_avail,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic [1:0]                     err_sticky
);

    localparam int GW  = $clog2(NUM_REQ);
    localparam int CW1 = CREDIT_W + 1;

    arb_state_t          r_state;
    logic [GW-1:0]       r_rr_ptr;
    logic                r_first;

    logic [NUM_REQ-1:0]  w_elig;
    logic [NUM_REQ-1:0]  w_rr_gnt;
    logic [GW-1:0]       w_rr_idx;
    logic [GW-1:0]       w_winner;
    logic [GW-1:0]       w_next_ptr;
    logic                w_crd_nz;
    logic                w_accept;
    logic [CW1-1:0]      w_crd_sum;

    // Only a valid start-of-packet beat may open a new grant.
    assign w_elig   = req_valid & req_sop;
    assign w_crd_nz = (crd_avail != '0);
    assign busy     = (r_state == XFER);
    assign w_accept = tx_valid & tx_ready;

    ucsie_rr_arbiter #(
        .N   (NUM_REQ)
    ) u_rr (
        .req (w_elig),
        .ptr (r_rr_ptr),
        .gnt (w_rr_gnt)
    );

    always_comb begin
        w_rr_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_rr_gnt[i]) begin
                w_rr_idx = GW'(i);
            end
        end
    end

`ifdef UCSIE_TX_ARB_PRIO_EN
    assign w_winner = w_elig[0] ? '0 : w_rr_idx;
`else
    assign w_winner = w_rr_idx;
`endif

    assign w_next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

    always_comb begin
        tx_data   = '0;
        tx_header = '0;
        tx_valid  = 1'b0;
        tx_sop    = 1'b0;
        tx_eop    = 1'b0;
        req_ready = '0;
        if (r_state == XFER) begin
            tx_data             = req_data[grant_id*DATA_W +: DATA_W];
            tx_header           = req_header[grant_id*UCSIE_HDR_W +: UCSIE_HDR_W];
            tx_sop              = req_sop[grant_id];
            tx_eop              = req_eop[grant_id];
            tx_valid            = req_valid[grant_id] & w_crd_nz;
            req_ready[grant_id] = tx_ready & w_crd_nz;
        end
    end

    // One extra bit of headroom so an over-return is visible before saturation.
    always_comb begin
        w_crd_sum = {1'b0, crd_avail} - {{CREDIT_W{1'b0}}, w_accept};
        if (crd_ret_vld) begin
            w_crd_sum = w_crd_sum + {1'b0, crd_ret_cnt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_first    <= 1'b0;
            grant_id   <= '0;
            crd_avail  <= CREDIT_W'(MAX_CREDIT);
            err_sticky <= '0;
        end else begin
            if (w_crd_sum > CW1'(MAX_CREDIT)) begin
                crd_avail     <= CREDIT_W'(MAX_CREDIT);
                err_sticky[0] <= 1'b1;
            end else begin
                crd_avail <= w_crd_sum[CREDIT_W-1:0];
            end

            case (r_state)
                IDLE: begin
                    if (link_ready && w_crd_nz && (|w_elig)) begin
                        grant_id <= w_winner;
                        r_first  <= 1'b1;
                        r_state  <= XFER;
                    end
                end
                XFER: begin
                    if (w_accept) begin
                        r_first <= 1'b0;
                        if (tx_sop && !r_first) begin
                            err_sticky[1] <= 1'b1;
                        end
                        if (tx_eop) begin
                            r_state <= IDLE;
`ifdef UCSIE_TX_ARB_PRIO_EN
                            if (grant_id != '0) begin
                                r_rr_ptr <= w_next_ptr;
                            end
`else
                            r_rr_ptr <= w_next_ptr;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
